// File: rtl/regdump_pkg.sv
// ============================================================================
//  Module   : regdump_pkg
//  Purpose  : Shared definitions for the RiSC-16 register-file dumper:
//             register-file geometry and the dumper state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regdump_pkg;

    // Register-file geometry, shared with the RiSC-16 register file.
    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 3;

    // Dumper states. LOAD is only reachable when the load path is built in.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SEND  = 3'd2,
        DONE  = 3'd3,
        LOAD  = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/regfile_dumper.sv
// ============================================================================
//  Module   : regfile_dumper
//  Purpose  : Debug reader for the 8 x 16-bit RiSC-16 register file. On a
//             dump_req pulse it walks the src1 read port from FIRST_REG to
//             LAST_REG and streams each value out on a valid/ready interface.
//             Optional macro REGDUMP_LOAD_EN adds a LOAD mode that writes a
//             stream of values into the register file via tgt/tgt_val/we_rf.
//  Ports    : clk, rst           - clock, asynchronous active-high reset
//             dump_req           - start pulse (sampled in IDLE only)
//             busy               - high whenever not IDLE
//             src1 / src1_val    - register-file read index / read data
//             out_data, out_idx  - streamed value and its register index
//             out_valid/ready    - stream handshake
//             out_last           - marks the LAST_REG beat
//             done               - one-cycle pulse after the final beat
//             (REGDUMP_LOAD_EN)  load_req, in_data, in_valid, in_ready,
//                                tgt, tgt_val, we_rf
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_dumper
    import regdump_pkg::*;
#(
    parameter int DATA_W    = RF_DATA_W,
    parameter int ADDR_W    = RF_ADDR_W,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dump_req,
    output logic              busy,
    output logic [ADDR_W-1:0] src1,
    input  logic [DATA_W-1:0] src1_val,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
`ifdef REGDUMP_LOAD_EN
    input  logic              load_req,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] tgt,
    output logic [DATA_W-1:0] tgt_val,
    output logic              we_rf,
`endif
    output logic              done
);

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

    state_e            state_q,     state_d;
    logic [ADDR_W-1:0] idx_q,       idx_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [ADDR_W-1:0] out_idx_q,   out_idx_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q,  out_last_d;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= FIRST_IDX;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        case (state_q)
            IDLE: begin
                if (dump_req) begin
                    state_d = FETCH;
                    idx_d   = FIRST_IDX;
                end
`ifdef REGDUMP_LOAD_EN
                else if (load_req) begin
                    state_d = LOAD;
                    idx_d   = FIRST_IDX;
                end
`endif
            end
            FETCH: begin
                // Capture the register value seen at this edge; later writes
                // to the same register do not disturb the pending beat.
                out_data_d  = src1_val;
                out_idx_d   = idx_q;
                out_valid_d = 1'b1;
                out_last_d  = (idx_q == LAST_IDX);
                state_d     = SEND;
            end
            SEND: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        state_d = DONE;
                    end else begin
                        // idx stops at LAST_REG, so this never wraps.
                        idx_d   = idx_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
`ifdef REGDUMP_LOAD_EN
            LOAD: begin
                if (in_valid) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
        // Parked on FIRST_REG when idle so the shared mux sees a stable index.
        src1 = (state_q == IDLE) ? FIRST_IDX : idx_q;
`ifdef REGDUMP_LOAD_EN
        in_ready = (state_q == LOAD);
        we_rf    = (state_q == LOAD) && in_valid;
        tgt      = (state_q == LOAD) ? idx_q   : '0;
        tgt_val  = (state_q == LOAD) ? in_data : '0;
`endif
    end

    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_dumper.sv
// ============================================================================
//  Module   : tb_regfile_dumper
//  Purpose  : Directed self-checking bench for regfile_dumper. A behavioural
//             register file feeds src1_val; a second instance covers the
//             single-register range (FIRST_REG = LAST_REG = 3).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_dumper;

    logic        clk = 1'b0;
    logic        rst;

    // main instance (0..7)
    logic        dump_req, out_ready;
    logic        busy, out_valid, out_last, done;
    logic [2:0]  src1, out_idx;
    logic [15:0] src1_val, out_data;

    // single-register instance (3..3)
    logic        dump_req2, out_ready2;
    logic        busy2, out_valid2, out_last2, done2;
    logic [2:0]  src1_2, out_idx2;
    logic [15:0] src1_val2, out_data2;

    // bench-side register-file write port
    logic        bw_en;
    logic [2:0]  bw_a;
    logic [15:0] bw_d;
    logic [15:0] rf [8];

    int checks   = 0;
    int failures = 0;

`ifdef REGDUMP_LOAD_EN
    logic        zero1 = 1'b0;
    logic [15:0] zero16 = 16'h0;
    logic        in_ready_a, we_rf_a, in_ready_b, we_rf_b;
    logic [2:0]  tgt_a, tgt_b;
    logic [15:0] tgt_val_a, tgt_val_b;
    // loader instance (1..7)
    logic        dump_req3, load_req3, in_valid3, in_ready3, we_rf3;
    logic        busy3, out_valid3, out_last3, done3, out_ready3;
    logic [2:0]  src1_3, out_idx3, tgt3;
    logic [15:0] src1_val3, out_data3, in_data3, tgt_val3;
`endif

    always #5 clk = ~clk;

    assign src1_val  = (src1   == 3'd0) ? 16'h0 : rf[src1];
    assign src1_val2 = (src1_2 == 3'd0) ? 16'h0 : rf[src1_2];

    always @(posedge clk) begin
        if (bw_en) rf[bw_a] <= bw_d;
`ifdef REGDUMP_LOAD_EN
        if (we_rf3) rf[tgt3] <= tgt_val3;
`endif
    end

    regfile_dumper #(.DATA_W(16), .ADDR_W(3), .FIRST_REG(0), .LAST_REG(7)) dut (
        .clk(clk), .rst(rst), .dump_req(dump_req), .busy(busy),
        .src1(src1), .src1_val(src1_val), .out_data(out_data),
        .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last),
`ifdef REGDUMP_LOAD_EN
        .load_req(zero1), .in_data(zero16), .in_valid(zero1),
        .in_ready(in_ready_a), .tgt(tgt_a), .tgt_val(tgt_val_a), .we_rf(we_rf_a),
`endif
        .done(done)
    );

    regfile_dumper #(.DATA_W(16), .ADDR_W(3), .FIRST_REG(3), .LAST_REG(3)) dut2 (
        .clk(clk), .rst(rst), .dump_req(dump_req2), .busy(busy2),
        .src1(src1_2), .src1_val(src1_val2), .out_data(out_data2),
        .out_idx(out_idx2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_last(out_last2),
`ifdef REGDUMP_LOAD_EN
        .load_req(zero1), .in_data(zero16), .in_valid(zero1),
        .in_ready(in_ready_b), .tgt(tgt_b), .tgt_val(tgt_val_b), .we_rf(we_rf_b),
`endif
        .done(done2)
    );

`ifdef REGDUMP_LOAD_EN
    assign src1_val3 = (src1_3 == 3'd0) ? 16'h0 : rf[src1_3];
    regfile_dumper #(.DATA_W(16), .ADDR_W(3), .FIRST_REG(1), .LAST_REG(7)) dut3 (
        .clk(clk), .rst(rst), .dump_req(dump_req3), .busy(busy3),
        .src1(src1_3), .src1_val(src1_val3), .out_data(out_data3),
        .out_idx(out_idx3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_last(out_last3),
        .load_req(load_req3), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .tgt(tgt3), .tgt_val(tgt_val3), .we_rf(we_rf3),
        .done(done3)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [2:0] idx,
                            input logic [15:0] data, input logic last);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_idx"},   {29'd0, out_idx},   {29'd0, idx});
        chk({tag, "_data"},  {16'd0, out_data},  {16'd0, data});
        chk({tag, "_last"},  {31'd0, out_last},  {31'd0, last});
    endtask

    task automatic bench_write(input logic [2:0] a, input logic [15:0] d);
        bw_en = 1'b1; bw_a = a; bw_d = d;
        tick();
        bw_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; dump_req = 1'b0; out_ready = 1'b1;
        dump_req2 = 1'b0; out_ready2 = 1'b1;
        bw_en = 1'b0; bw_a = 3'd0; bw_d = 16'h0;
`ifdef REGDUMP_LOAD_EN
        dump_req3 = 1'b0; load_req3 = 1'b0; in_valid3 = 1'b0;
        in_data3 = 16'h0; out_ready3 = 1'b1;
`endif
        // preload r1..r7 = 0x11 * n while held in reset
        for (int i = 1; i < 8; i++) bench_write(3'(i), 16'(i * 17));

        // ---------------- reset state ----------------
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_src1",      {29'd0, src1},      32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  {16'd0, out_data},  32'd0);
        chk("rst_out_idx",   {29'd0, out_idx},   32'd0);
        chk("rst_out_last",  {31'd0, out_last},  32'd0);
        chk("rst_done",      {31'd0, done},      32'd0);
        chk("rst_src1_dut2", {29'd0, src1_2},    32'd3);
        rst = 1'b0;
        tick();

        // ---------------- full dump, out_ready high ----------------
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        chk("d1_busy",     {31'd0, busy},      32'd1);
        chk("d1_early_vd", {31'd0, out_valid}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_beat("d1_beat", 3'(k), 16'(k * 17), (k == 7));
            tick();
            chk("d1_gap_valid", {31'd0, out_valid}, 32'd0);
            chk("d1_done",      {31'd0, done},      {31'd0, (k == 7)});
            if (k < 7) chk("d1_src1", {29'd0, src1}, 32'(k + 1));
        end
        tick();
        chk("d1_done_clr", {31'd0, done}, 32'd0);
        chk("d1_idle",     {31'd0, busy}, 32'd0);

        // ---------------- backpressure and write coherence ----------------
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_beat("d2_beat", 3'(k), 16'(k * 17), 1'b0);
            tick();
        end
        // r2 already streamed; stall the idx 3 beat
        out_ready = 1'b0;
        bench_write(3'd2, 16'hBEEF);
        chk_beat("d2_beat3", 3'd3, 16'h0033, 1'b0);
        for (int s = 0; s < 5; s++) begin
            tick();
            chk_beat("d2_hold", 3'd3, 16'h0033, 1'b0);
            chk("d2_hold_busy", {31'd0, busy}, 32'd1);
            chk("d2_hold_src1", {29'd0, src1}, 32'd3);
        end
        out_ready = 1'b1;
        tick();
        chk("d2_rel_gap", {31'd0, out_valid}, 32'd0);
        tick();
        chk_beat("d2_beat4", 3'd4, 16'h0044, 1'b0);
        // write r5 on the edge that enters FETCH of idx 5
        bench_write(3'd5, 16'd53);
        chk("d2_gap5", {31'd0, out_valid}, 32'd0);
        tick();
        chk_beat("d2_beat5", 3'd5, 16'd53, 1'b0);
        for (int k = 6; k < 8; k++) begin
            tick();
            tick();
            chk_beat("d2_beat", 3'(k), 16'(k * 17), (k == 7));
        end
        tick();
        chk("d2_done", {31'd0, done}, 32'd1);
        tick();
        bench_write(3'd2, 16'h0022);
        bench_write(3'd5, 16'h0055);

        // ---------------- ignored request, reset mid-dump ----------------
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_beat("d3_beat", 3'(k), 16'(k * 17), 1'b0);
            if (k < 4) begin
                if (k == 1) dump_req = 1'b1;
                tick();
                dump_req = 1'b0;
            end
        end
        #2;
        rst = 1'b1;
        #1;
        chk("d3_async_valid", {31'd0, out_valid}, 32'd0);
        chk("d3_async_busy",  {31'd0, busy},      32'd0);
        chk("d3_async_idx",   {29'd0, out_idx},   32'd0);
        chk("d3_async_data",  {16'd0, out_data},  32'd0);
        chk("d3_async_src1",  {29'd0, src1},      32'd0);
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("d3_rst_done", {31'd0, done}, 32'd0);
        end
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("d3_post_done",  {31'd0, done},      32'd0);
            chk("d3_post_busy",  {31'd0, busy},      32'd0);
            chk("d3_post_valid", {31'd0, out_valid}, 32'd0);
        end

        // ---------------- single-register range ----------------
        dump_req2 = 1'b1;
        tick();
        dump_req2 = 1'b0;
        chk("s_busy",  {31'd0, busy2},      32'd1);
        chk("s_src1",  {29'd0, src1_2},     32'd3);
        chk("s_early", {31'd0, out_valid2}, 32'd0);
        tick();
        chk("s_valid", {31'd0, out_valid2}, 32'd1);
        chk("s_idx",   {29'd0, out_idx2},   32'd3);
        chk("s_data",  {16'd0, out_data2},  32'h33);
        chk("s_last",  {31'd0, out_last2},  32'd1);
        tick();
        chk("s_done",     {31'd0, done2},      32'd1);
        chk("s_valid_lo", {31'd0, out_valid2}, 32'd0);
        tick();
        chk("s_done_clr", {31'd0, done2}, 32'd0);
        chk("s_idle",     {31'd0, busy2}, 32'd0);

`ifdef REGDUMP_LOAD_EN
        // ---------------- load r1..r7 = 5..11, then dump ----------------
        load_req3 = 1'b1;
        tick();
        load_req3 = 1'b0;
        chk("l_busy",  {31'd0, busy3},     32'd1);
        chk("l_ready", {31'd0, in_ready3}, 32'd1);
        chk("l_we_lo", {31'd0, we_rf3},    32'd0);
        for (int j = 0; j < 7; j++) begin
            in_valid3 = 1'b1;
            in_data3  = 16'(5 + j);
            #1;
            chk("l_we",  {31'd0, we_rf3},   32'd1);
            chk("l_tgt", {29'd0, tgt3},     32'(1 + j));
            chk("l_val", {16'd0, tgt_val3}, 32'(5 + j));
            tick();
        end
        in_valid3 = 1'b0;
        chk("l_done",    {31'd0, done3},  32'd1);
        chk("l_we_done", {31'd0, we_rf3}, 32'd0);
        tick();
        chk("l_idle", {31'd0, busy3}, 32'd0);
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_beat("l_dump", 3'(k), (k == 0) ? 16'h0 : 16'(4 + k), (k == 7));
            tick();
        end
        chk("l_dump_done", {31'd0, done}, 32'd1);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
